dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arb_pkg.sv | 11 +
 rtl/dm_lane_unit.sv | 27 ++
 rtl/dm_arbiter.sv | 128 ++++++++++++
 tb/tb_dm_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// dm_arb_pkg: size encodings, FSM states and request-shape check for dm_arbiter.
package dm_arb_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {IDLE, ACCESS, MERGE} state_t;
  // True for an illegal size or an address not aligned to its size.
  function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] lo);
    return size == SZ_HALF ? lo[0] : size == SZ_WORD ? |lo : size != SZ_BYTE;
  endfunction
endpackage

// File: rtl/dm_lane_unit.sv
// dm_lane_unit: lane extract/extend for loads and lane merge for sub-word stores.
module dm_lane_unit
  import dm_arb_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ext_o,
  output logic [31:0] merged_o
);
  logic [4:0] sh;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] mask;
  always_comb begin
    sh = {off_i, 3'b000};
    b = 8'(word_i >> sh);
    h = 16'(word_i >> sh);
    ext_o = size_i == SZ_BYTE ? {{24{sign_i & b[7]}}, b} :
            size_i == SZ_HALF ? {{16{sign_i & h[15]}}, h} : word_i;
    mask = size_i == SZ_BYTE ? 32'h0000_00FF << sh :
           size_i == SZ_HALF ? 32'h0000_FFFF << sh : 32'hFFFF_FFFF;
    merged_o = (word_i & ~mask) | ((wdata_i << sh) & mask);
  end
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port round-robin arbiter onto a single-word data memory,
// with sub-word loads and read-modify-write sub-word stores.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_sign,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_sign,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [32:0] LIMIT = 33'(4 * MEM_WORDS);
  state_t state_q;
  logic prio_q, port_q, we_q, sign_q;
  logic [1:0] size_q;
  logic [31:0] addr_q, wdata_q, merge_q;
  logic [1:0] rvalid_q, err_q;
  logic [1:0][31:0] rdata_q;
  logic gnt0, gnt1, sel, req_we, req_sign, req_bad, is_word;
  logic [1:0] req_size;
  logic [31:0] req_addr, req_wdata, ext, merged;
  // prio_q names the port that wins a tie; it flips away from each grantee.
  assign gnt0 = !reset && state_q == IDLE && p0_valid && (!p1_valid || !prio_q);
  assign gnt1 = !reset && state_q == IDLE && p1_valid && (!p0_valid || prio_q);
  assign p0_ready = gnt0;
  assign p1_ready = gnt1;
  assign sel = gnt1;
  assign req_we = sel ? p1_we : p0_we;
  assign req_size = sel ? p1_size : p0_size;
  assign req_sign = sel ? p1_sign : p0_sign;
  assign req_addr = sel ? p1_addr : p0_addr;
  assign req_wdata = sel ? p1_wdata : p0_wdata;
  assign req_bad = bad_shape(req_size, req_addr[1:0]) || {1'b0, req_addr} >= LIMIT;
  assign is_word = size_q == SZ_WORD;
  assign mem_read = !reset && state_q == ACCESS && !(we_q && is_word);
  assign mem_write = !reset && (state_q == MERGE || (state_q == ACCESS && we_q && is_word));
  assign mem_addr = {addr_q[31:2], 2'b00};
  assign mem_wdata = state_q == MERGE ? merged : wdata_q;
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_rdata = rdata_q[0];
  assign p1_rdata = rdata_q[1];
  assign p0_err = err_q[0];
  assign p1_err = err_q[1];
  dm_lane_unit u_lane (
    .word_i  (state_q == MERGE ? merge_q : mem_rdata),
    .off_i   (addr_q[1:0]),
    .size_i  (size_q),
    .sign_i  (sign_q),
    .wdata_i (wdata_q),
    .ext_o   (ext),
    .merged_o(merged)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prio_q <= 1'b0;
      port_q <= 1'b0;
      we_q <= 1'b0;
      sign_q <= 1'b0;
      size_q <= SZ_BYTE;
      addr_q <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rvalid_q <= '0;
      err_q <= '0;
      rdata_q <= '0;
    end else begin
      rvalid_q <= '0;
      case (state_q)
        IDLE: if (gnt0 || gnt1) begin
          port_q <= sel;
          prio_q <= !sel;
          we_q <= req_we;
          size_q <= req_size;
          sign_q <= req_sign;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          if (req_bad) begin
            rvalid_q[sel] <= 1'b1;
            err_q[sel] <= 1'b1;
            rdata_q[sel] <= '0;
          end else state_q <= ACCESS;
        end
        ACCESS: if (we_q && !is_word) begin
          merge_q <= mem_rdata;
          state_q <= MERGE;
        end else begin
          rvalid_q[port_q] <= 1'b1;
          err_q[port_q] <= 1'b0;
          rdata_q[port_q] <= we_q ? '0 : ext;
          state_q <= IDLE;
        end
        MERGE: begin
          rvalid_q[port_q] <= 1'b1;
          err_q[port_q] <= 1'b0;
          rdata_q[port_q] <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed and randomized checks of dm_arbiter against a byte-level
// memory model with per-request latency and round-robin grant rules.
module tb_dm_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] vld = '0, we = '0, sgn = '0;
  logic [1:0][1:0] sz = '0;
  logic [1:0][31:0] ad = '0, wd = '0;
  wire [1:0] rdy, rv, er;
  wire [1:0][31:0] rd;
  wire mem_read, mem_write;
  wire [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] dev [1024];
  byte unsigned mb [4096];
  int n_chk = 0, n_fail = 0, cyc = 0;

  dm_arbiter #(.MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .p0_valid(vld[0]), .p0_ready(rdy[0]), .p0_we(we[0]), .p0_size(sz[0]), .p0_sign(sgn[0]),
    .p0_addr(ad[0]), .p0_wdata(wd[0]), .p0_rvalid(rv[0]), .p0_rdata(rd[0]), .p0_err(er[0]),
    .p1_valid(vld[1]), .p1_ready(rdy[1]), .p1_we(we[1]), .p1_size(sz[1]), .p1_sign(sgn[1]),
    .p1_addr(ad[1]), .p1_wdata(wd[1]), .p1_rvalid(rv[1]), .p1_rdata(rd[1]), .p1_err(er[1]),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = dev[mem_addr[11:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) dev[mem_addr[11:2]] <= mem_wdata;
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return 1 << s;
  endfunction

  function automatic bit is_bad(input logic [1:0] s, input logic [31:0] a);
    return s == 2'b11 || (a % nbytes(s)) != 0 || a >= 4096;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] a, input logic [1:0] s, input bit sg);
    logic [31:0] v = 0;
    int n = nbytes(s);
    for (int i = 0; i < n; i++) v |= 32'(mb[12'(a + i)]) << (8 * i);
    if (sg && n < 4 && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  function automatic logic [31:0] merged_word(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    byte unsigned b [4];
    logic [31:0] base = a & ~32'd3;
    logic [31:0] w = 0;
    for (int i = 0; i < 4; i++) b[i] = mb[12'(base + i)];
    for (int i = 0; i < nbytes(s); i++) b[2'(a - base + i)] = d[8 * i +: 8];
    for (int i = 0; i < 4; i++) w |= 32'(b[i]) << (8 * i);
    return w;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [31:0] v);
    dev[a[11:2]] = v;
    for (int i = 0; i < 4; i++) mb[12'(a + i)] = v[8 * i +: 8];
  endtask

  // Reference model: one outstanding request, its due cycle and expected effects.
  bit mprio, out_v, out_we, out_err, dp;
  int out_p, out_due, out_nr, out_nw, nr, nw, gp;
  logic [1:0] out_size, g;
  logic [31:0] out_addr, out_wdata, out_rdata, out_wword;
  logic [31:0] last_rd [2];
  bit last_er [2];

  task automatic apply_store();
    if (out_we && !out_err)
      for (int i = 0; i < nbytes(out_size); i++) mb[12'(out_addr + i)] = 8'(out_wdata >> (8 * i));
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk(!mem_read && !mem_write, "rst_mem_idle", 32'({mem_read, mem_write}), 32'd0);
      chk(rdy == 2'b00, "rst_ready", 32'(rdy), 32'd0);
      if (out_v && out_due == cyc) apply_store();
      out_v = 0; mprio = 0; nr = 0; nw = 0;
      last_rd[0] = 0; last_rd[1] = 0; last_er[0] = 0; last_er[1] = 0;
    end else begin
      chk(!(mem_read && mem_write), "mem_excl", 32'({mem_read, mem_write}), 32'd0);
      if (mem_read) begin
        nr++;
        chk(mem_addr == {out_addr[31:2], 2'b00}, "rd_addr", mem_addr, {out_addr[31:2], 2'b00});
      end
      if (mem_write) begin
        nw++;
        chk(mem_addr == {out_addr[31:2], 2'b00}, "wr_addr", mem_addr, {out_addr[31:2], 2'b00});
        chk(mem_wdata == out_wword, "wr_data", mem_wdata, out_wword);
      end
      for (int p = 0; p < 2; p++) begin
        dp = out_v && out_due == cyc && out_p == p;
        chk(rv[p] == dp, $sformatf("p%0d_rvalid", p), 32'(rv[p]), 32'(dp));
        if (dp) begin
          chk(rd[p] == out_rdata, $sformatf("p%0d_rdata", p), rd[p], out_rdata);
          chk(er[p] == out_err, $sformatf("p%0d_err", p), 32'(er[p]), 32'(out_err));
          chk(nr == out_nr && nw == out_nw, "mem_access_count", 32'(nr * 16 + nw), 32'(out_nr * 16 + out_nw));
          apply_store();
          last_rd[p] = out_rdata;
          last_er[p] = out_err;
          out_v = 0; nr = 0; nw = 0;
        end else begin
          chk(rd[p] == last_rd[p], $sformatf("p%0d_rdata_hold", p), rd[p], last_rd[p]);
          chk(er[p] == last_er[p], $sformatf("p%0d_err_hold", p), 32'(er[p]), 32'(last_er[p]));
        end
      end
      if (!out_v) begin
        chk(nr == 0 && nw == 0, "idle_access", 32'(nr + nw), 32'd0);
        nr = 0; nw = 0;
      end
      g[0] = !out_v && vld[0] && (!vld[1] || !mprio);
      g[1] = !out_v && vld[1] && (!vld[0] || mprio);
      chk(rdy == g, "ready", 32'(rdy), 32'(g));
      if (g != 2'b00) begin
        gp = int'(g[1]);
        mprio = !g[1];
        out_v = 1; out_p = gp; out_we = we[gp]; out_size = sz[gp];
        out_addr = ad[gp]; out_wdata = wd[gp]; out_wword = wd[gp];
        out_rdata = 0; out_err = 0; out_nr = 0; out_nw = 0;
        if (is_bad(out_size, out_addr)) begin
          out_err = 1; out_due = cyc + 1;
        end else if (!out_we) begin
          out_due = cyc + 2; out_nr = 1; out_rdata = load_val(out_addr, out_size, sgn[gp]);
        end else if (out_size == 2'b10) begin
          out_due = cyc + 2; out_nw = 1;
        end else begin
          out_due = cyc + 3; out_nr = 1; out_nw = 1;
          out_wword = merged_word(out_addr, out_size, out_wdata);
        end
      end
    end
  end

  task automatic do_req(input int p, input bit w, input logic [1:0] s, input bit sg,
                        input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input logic [31:0] exp_rd, input bit exp_er, input string name);
    int lat = 0;
    bit got = 0;
    @(posedge clk); #1;
    vld[p] = 1; we[p] = w; sz[p] = s; sgn[p] = sg; ad[p] = a; wd[p] = d;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = rdy[p]; end
    chk(got, {name, "_grant"}, 32'(got), 32'd1);
    @(posedge clk); #1;
    vld[p] = 0;
    got = 0;
    while (!got && lat < 10) begin @(negedge clk); lat++; got = rv[p]; end
    chk(lat == exp_lat, {name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk(rd[p] == exp_rd, {name, "_rdata"}, rd[p], exp_rd);
    chk(er[p] == exp_er, {name, "_err"}, 32'(er[p]), 32'(exp_er));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [1:0] acc;
    int order [4];
    int bad;
    bit got;
    logic [1:0] seen;
    logic [31:0] e;
    for (int i = 0; i < 1024; i++) poke(32'(i * 4), $urandom);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk(rv == 2'b00, "reset_rvalid", 32'(rv), 32'd0);
    chk(rd[0] == 0 && rd[1] == 0, "reset_rdata", rd[0] | rd[1], 32'd0);
    chk(er == 2'b00, "reset_err", 32'(er), 32'd0);

    do_req(0, 1, 2'b10, 0, 32'h10, 32'h1234_5678, 2, 32'h0, 0, "st_word");
    do_req(0, 0, 2'b10, 0, 32'h10, 32'h0, 2, 32'h1234_5678, 0, "ld_word");
    poke(32'h20, 32'hAABB_CCDD);
    do_req(1, 1, 2'b00, 0, 32'h22, 32'h11, 3, 32'h0, 0, "st_byte");
    chk(dev[8] == 32'hAA11_CCDD, "st_byte_mem", dev[8], 32'hAA11_CCDD);
    poke(32'h4, 32'h0000_8001);
    do_req(0, 0, 2'b01, 1, 32'h4, 32'h0, 2, 32'hFFFF_8001, 0, "ld_half_s");
    do_req(1, 0, 2'b01, 0, 32'h4, 32'h0, 2, 32'h0000_8001, 0, "ld_half_u");
    do_req(0, 0, 2'b01, 0, 32'h3, 32'h0, 1, 32'h0, 1, "err_misalign");
    do_req(1, 0, 2'b10, 0, 32'h1000, 32'h0, 1, 32'h0, 1, "err_range");
    do_req(0, 0, 2'b11, 0, 32'h8, 32'h0, 1, 32'h0, 1, "err_size");

    // Round robin with both ports valid straight after reset.
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    we = 2'b00; sz[0] = 2'b10; sz[1] = 2'b10; ad[0] = 32'h0; ad[1] = 32'h8; vld = 2'b11;
    for (int k = 0; k < 4; k++) begin
      got = 0;
      order[k] = -1;
      for (int i = 0; i < 10 && !got; i++) begin
        @(negedge clk);
        if (rdy != 2'b00) begin order[k] = int'(rdy[1]); got = 1; end
      end
      @(posedge clk); #1;
    end
    vld = 2'b00;
    for (int k = 0; k < 4; k++) chk(order[k] == k % 2, $sformatf("rr_grant%0d", k), 32'(order[k]), 32'(k % 2));
    repeat (4) @(posedge clk);

    // Reset during MERGE drops the write and the response, and resets the pointer.
    poke(32'h30, 32'h0102_0304);
    #1;
    vld[0] = 1; we[0] = 1; sz[0] = 2'b00; sgn[0] = 0; ad[0] = 32'h31; wd[0] = 32'h5A;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clk); got = rdy[0]; end
    chk(got, "merge_rst_grant", 32'(got), 32'd1);
    @(posedge clk); #1 vld[0] = 0;
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    chk(mem_write == 0, "merge_rst_write", 32'(mem_write), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); seen |= rv; end
    chk(seen == 2'b00, "merge_rst_no_rvalid", 32'(seen), 32'd0);
    chk(dev[12] == 32'h0102_0304, "merge_rst_mem", dev[12], 32'h0102_0304);
    @(posedge clk); #1;
    we = 2'b00; sz[0] = 2'b10; sz[1] = 2'b10; ad[0] = 32'h0; ad[1] = 32'h4; vld = 2'b11;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = rdy != 2'b00; acc = rdy; end
    chk(acc == 2'b01, "post_rst_grant", 32'(acc), 32'd1);
    @(posedge clk); #1 vld[0] = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin @(negedge clk); got = rdy[1]; end
    @(posedge clk); #1 vld[1] = 0;
    repeat (4) @(posedge clk);

    // Randomized traffic; a request is held until granted.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      acc = rdy;
      @(posedge clk); #1;
      if (reset) reset = 0;
      else if ($urandom_range(0, 399) == 0) reset = 1;
      for (int p = 0; p < 2; p++)
        if (acc[p] || !vld[p]) begin
          vld[p] = $urandom_range(0, 99) < 60;
          we[p] = 1'($urandom_range(0, 1));
          sz[p] = $urandom_range(0, 19) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
          sgn[p] = 1'($urandom_range(0, 1));
          wd[p] = $urandom;
          ad[p] = $urandom_range(0, 99) < 93 ? 32'($urandom_range(0, 255)) :
                  $urandom_range(0, 1) == 0 ? 32'($urandom_range(4088, 4200)) : $urandom;
        end
    end
    vld = 2'b00;
    reset = 0;
    repeat (10) @(posedge clk);
    bad = 0;
    for (int w = 0; w < 1024; w++) begin
      e = {mb[4 * w + 3], mb[4 * w + 2], mb[4 * w + 1], mb[4 * w]};
      if (dev[w] != e) bad++;
    end
    chk(bad == 0, "mem_image", 32'(bad), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
